// File: rtl/muldiv_unit_if.sv
// muldiv_unit_if: start/op/operand request and busy/done/result/flags response bundle between execute stage (master) and muldiv_unit (slave)
interface muldiv_unit_if #(parameter int WIDTH = 32);
  logic start;
  logic [1:0] op;
  logic [WIDTH-1:0] a_in;
  logic [WIDTH-1:0] b_in;
  logic busy;
  logic done;
  logic [WIDTH-1:0] ALUResult;
  logic Z;
  logic NEG;
  modport master(output start, op, a_in, b_in, input busy, done, ALUResult, Z, NEG);
  modport slave(input start, op, a_in, b_in, output busy, done, ALUResult, Z, NEG);
endinterface

// File: rtl/muldiv_unit.sv
// muldiv_unit: radix-2 multi-cycle MUL/MULHU/DIVU/REMU; ports clk, reset (sync, active-high), bus (slave: start/op/a_in/b_in in, busy/done/ALUResult/Z/NEG out)
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input logic clk,
  input logic reset,
  muldiv_unit_if.slave bus
);
  localparam int CW = $clog2(WIDTH) + 1;
  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;
  state_t state;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] m;
  logic op0;
  logic dz;
  logic [CW-1:0] cnt;
  logic [WIDTH:0] msum;
  logic [WIDTH:0] rtry;
  logic [WIDTH-1:0] res;
  always_comb begin
    msum = {1'b0, acc} + {1'b0, q[0] ? m : '0};
    rtry = {acc, q[WIDTH-1]} - {1'b0, m};
    res = dz ? (op0 ? q : '1) : (op0 ? acc : q);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      bus.busy <= 1'b0;
      bus.done <= 1'b0;
      bus.ALUResult <= '0;
      bus.Z <= 1'b1;
      bus.NEG <= 1'b0;
      acc <= '0;
      q <= '0;
      m <= '0;
      op0 <= 1'b0;
      dz <= 1'b0;
      cnt <= '0;
    end else begin
      bus.done <= 1'b0;
      if (state == IDLE || state == DONE) begin
        if (bus.start) begin
          state <= bus.op[1] ? DIV : MUL;
          bus.busy <= 1'b1;
          acc <= '0;
          q <= bus.op[1] ? bus.a_in : bus.b_in;
          m <= bus.op[1] ? bus.b_in : bus.a_in;
          op0 <= bus.op[0];
          dz <= bus.op[1] && bus.b_in == '0;
          cnt <= '0;
        end else begin
          state <= IDLE;
          bus.busy <= 1'b0;
        end
      end else if (dz || cnt == CW'(WIDTH)) begin
        state <= DONE;
        bus.busy <= 1'b0;
        bus.done <= 1'b1;
        bus.ALUResult <= res;
        bus.Z <= res == '0;
        bus.NEG <= res[WIDTH-1];
      end else begin
        cnt <= cnt + 1'b1;
        if (state == MUL)
          {acc, q} <= {msum, q[WIDTH-1:1]};
        else begin
          acc <= rtry[WIDTH] ? {acc[WIDTH-2:0], q[WIDTH-1]} : rtry[WIDTH-1:0];
          q <= {q[WIDTH-2:0], ~rtry[WIDTH]};
        end
      end
    end
  end
endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: table-driven and scoreboarded check of muldiv_unit results, flags, latency, reset abort, ignored and back-to-back starts
module tb_muldiv_unit;
  localparam int W = 32;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;
  muldiv_unit_if #(.WIDTH(W)) bus();
  muldiv_unit #(.WIDTH(W)) dut(.clk(clk), .reset(reset), .bus(bus));
  typedef struct {logic [1:0] op; logic [W-1:0] a; logic [W-1:0] b; logic [W-1:0] res;} vec_t;
  typedef struct {logic [W-1:0] res; int due; int id;} exp_t;
  exp_t sb[$];
  int cyc = 0;
  int nvec = 0;
  int nbad = 0;
  int nid = 0;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] want);
    nvec++;
    if (act !== want) begin
      nbad++;
      $display("FAIL %s: got %h, want %h (cycle %0d)", name, act, want, cyc);
    end
  endtask
  function automatic logic [W-1:0] model(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    logic [2*W-1:0] p;
    p = {{W{1'b0}}, a} * {{W{1'b0}}, b};
    case (op)
      2'b00: return p[W-1:0];
      2'b01: return p[2*W-1:W];
      2'b10: return b == 0 ? '1 : a / b;
      default: return b == 0 ? a : a % b;
    endcase
  endfunction
  always @(posedge clk) begin
    #1;
    if (bus.done === 1'b1) begin
      if (sb.size() == 0) check("spurious done", {{(W-1){1'b0}}, bus.done}, '0);
      else begin
        exp_t e;
        e = sb.pop_front();
        check($sformatf("result #%0d", e.id), bus.ALUResult, e.res);
        check($sformatf("Z #%0d", e.id), {{(W-1){1'b0}}, bus.Z}, {{(W-1){1'b0}}, e.res == '0});
        check($sformatf("NEG #%0d", e.id), {{(W-1){1'b0}}, bus.NEG}, {{(W-1){1'b0}}, e.res[W-1]});
        check($sformatf("done cycle #%0d", e.id), cyc, e.due);
        check($sformatf("busy at done #%0d", e.id), {{(W-1){1'b0}}, bus.busy}, '0);
      end
    end
  end
  task automatic drive(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    bus.start = 1'b1;
    bus.op = op;
    bus.a_in = a;
    bus.b_in = b;
  endtask
  task automatic push(input logic [1:0] op, input logic [W-1:0] b, input logic [W-1:0] res, input int base);
    sb.push_back('{res, base + ((op[1] && b == 0) ? 1 : W + 1), nid});
    nid++;
  endtask
  task automatic issue(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] res);
    drive(op, a, b);
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    push(op, b, res, cyc);
  endtask
  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("drain timeout", sb.size(), 0);
    sb.delete();
    @(posedge clk);
    #1;
  endtask
  vec_t vt[$];
  initial begin
    logic all_busy;
    int k;
    bus.start = 1'b0;
    bus.op = 2'b00;
    bus.a_in = '0;
    bus.b_in = '0;
    vt.push_back('{2'b00, 32'd7, 32'd6, 32'd42});
    vt.push_back('{2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE});
    vt.push_back('{2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001});
    vt.push_back('{2'b10, 32'd100, 32'd7, 32'd14});
    vt.push_back('{2'b11, 32'd100, 32'd7, 32'd2});
    vt.push_back('{2'b10, 32'd5, 32'd9, 32'd0});
    vt.push_back('{2'b10, 32'h1234, 32'd0, 32'hFFFFFFFF});
    vt.push_back('{2'b11, 32'h1234, 32'd0, 32'h00001234});
    vt.push_back('{2'b01, 32'h80000000, 32'h00000002, 32'h00000001});
    vt.push_back('{2'b11, 32'hFFFFFFFF, 32'h00000010, 32'h0000000F});
    for (int i = 0; i < 8; i++) begin
      logic [1:0] op;
      logic [W-1:0] a, b;
      op = 2'($urandom_range(0, 3));
      a = $urandom;
      b = (i == 3) ? '0 : $urandom >> $urandom_range(0, 28);
      vt.push_back('{op, a, b, model(op, a, b)});
    end
    repeat (3) @(posedge clk);
    #1;
    check("reset busy", {{(W-1){1'b0}}, bus.busy}, '0);
    check("reset done", {{(W-1){1'b0}}, bus.done}, '0);
    check("reset ALUResult", bus.ALUResult, '0);
    check("reset Z", {{(W-1){1'b0}}, bus.Z}, 1);
    check("reset NEG", {{(W-1){1'b0}}, bus.NEG}, '0);
    reset = 1'b0;
    @(posedge clk);
    #1;
    for (int i = 0; i < vt.size(); i++) begin
      issue(vt[i].op, vt[i].a, vt[i].b, vt[i].res);
      drain();
    end
    issue(2'b00, 32'd7, 32'd6, 32'd42);
    all_busy = 1'b1;
    for (int i = 0; i < W; i++) begin
      all_busy &= bus.busy;
      @(posedge clk);
      #1;
    end
    check("busy while multiplying", {{(W-1){1'b0}}, all_busy}, 1);
    drain();
    drive(2'b00, 32'd5, 32'd3);
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    check("abort busy", {{(W-1){1'b0}}, bus.busy}, '0);
    check("abort ALUResult", bus.ALUResult, '0);
    check("abort Z", {{(W-1){1'b0}}, bus.Z}, 1);
    repeat (2) @(posedge clk);
    #1;
    issue(2'b00, 32'd7, 32'd6, 32'd42);
    drain();
    issue(2'b10, 32'd100, 32'd7, 32'd14);
    repeat (5) @(posedge clk);
    #1;
    drive(2'b00, 32'd3, 32'd3);
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    drain();
    repeat (3) @(posedge clk);
    #1;
    drive(2'b00, 32'd7, 32'd6);
    @(posedge clk);
    #1;
    push(2'b00, 32'd6, 32'd42, cyc);
    k = cyc;
    drive(2'b11, 32'd100, 32'd7);
    repeat (W + 1) @(posedge clk);
    #1;
    check("done before second accept", {{(W-1){1'b0}}, bus.done}, 1);
    push(2'b11, 32'd7, 32'd2, k + W + 2);
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    drain();
    repeat (4) @(posedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
    $finish;
  end
endmodule
